// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the transmitter and receiver.
// Frame layout: two 32-bit slots, 24-bit samples, MSB first.
package i2s_pkg;

  localparam int DATA_W     = 24;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  // Slot image in send order, including the one-bit I2S delay.
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [DATA_W-1:0] l,
    input logic [DATA_W-1:0] r
  );
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

endpackage

// File: rtl/i2s_transmitter_clk_gen.sv
// Bit-clock divider: i2s_bclk plus one-clk edge strobes.
// Strobes are high in the clk cycle that produces the edge.
module i2s_clk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_bclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div;
  logic       r_bclk;
  logic       w_tick;

  assign w_tick = i_en && (r_div == LAST);
  assign o_rise = w_tick & ~r_bclk;
  assign o_fall = w_tick & r_bclk;
  assign o_bclk = r_bclk;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_tick) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + 8'd1;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S stereo transmitter with one-deep holding register.
// Everything runs on clk; bclk edges come in as strobes.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_left,
  input  logic [DATA_W-1:0] sample_right,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_data,
  output logic              underrun
);

  state_t                r_state;
  logic                  r_first;
  logic [5:0]            r_cnt;
  logic [FRAME_BITS-1:0] r_sh;
  logic [DATA_W-1:0]     r_hl;
  logic [DATA_W-1:0]     r_hr;
  logic                  r_full;
  logic                  r_lrclk;
  logic                  r_data;
  logic                  r_underrun;

  logic                  w_en;
  logic                  w_fall;
  logic                  w_unused_rise;
  logic                  w_acc;
  logic [5:0]            w_next;
  logic                  w_bound;
  logic [FRAME_BITS-1:0] w_load;

  assign w_en    = (r_state == RUN);
  assign w_acc   = sample_valid & ~r_full;
  assign w_next  = r_first ? 6'd0 : r_cnt + 6'd1;
  assign w_bound = w_fall & (w_next == 6'd0);
  assign w_load  = r_full ? pack_frame(r_hl, r_hr) : '0;

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_en),
    .o_bclk  (i2s_bclk),
    .o_rise  (w_unused_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_first    <= 1'b1;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_hl       <= '0;
      r_hr       <= '0;
      r_full     <= 1'b0;
      r_lrclk    <= 1'b1;
      r_data     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_bound & ~r_full;
      if (w_acc) begin
        r_hl <= sample_left;
        r_hr <= sample_right;
      end
      // A pair offered at an empty boundary is held for the next frame.
      if (w_bound) r_full <= ~r_full & w_acc;
      else         r_full <= r_full | w_acc;
      unique case (r_state)
        IDLE: if (w_acc) r_state <= RUN;
        RUN:  r_state <= RUN;
      endcase
      if (w_fall) begin
        r_first <= 1'b0;
        r_cnt   <= w_next;
        r_lrclk <= w_next[5];
        if (w_bound) begin
          r_data <= w_load[FRAME_BITS-1];
          r_sh   <= {w_load[FRAME_BITS-2:0], 1'b0};
        end else begin
          r_data <= r_sh[FRAME_BITS-1];
          r_sh   <= {r_sh[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign sample_ready = ~r_full;
  assign i2s_lrclk    = r_lrclk;
  assign i2s_data     = r_data;
  assign underrun     = r_underrun;

endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, meaning clk cycles per i2s_bclk half-period (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock (50 MHz CLOCK_50 domain).
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sample_left  input  24  left sample, two's complement.
REQ-005 SHALL have port sample_right  input  24  right sample, two's complement.
REQ-006 SHALL have port sample_valid  input  1  producer offers a stereo pair.
REQ-007 SHALL have port sample_ready  output  1  holding register empty; pair accepted when valid&ready.
REQ-008 SHALL have port i2s_bclk  output  1  bit clock to CODEC.
REQ-009 SHALL have port i2s_lrclk  output  1  word select; 0 = left, 1 = right.
REQ-010 SHALL have port i2s_data  output  1  serial data, MSB first.
REQ-011 SHALL have port underrun  output  1  one-clk pulse when a frame starts with no sample held.

Function
REQ-012 FSM SHALL have states IDLE and RUN; IDLE -> RUN on first accepted pair; RUN -> IDLE only on reset.
REQ-013 In IDLE: i2s_bclk=0, i2s_lrclk=1, i2s_data=0, divider and bit counter held at 0.
REQ-014 In RUN, i2s_bclk SHALL toggle every CLK_DIV clk cycles, first rising edge CLK_DIV cycles after entering RUN.
REQ-015 A 6-bit bit counter SHALL advance on each bclk falling edge; frame = 64 bclk periods (two 32-bit slots), wrapping 63 -> 0.
REQ-016 i2s_lrclk and i2s_data SHALL change only on the clk cycle producing a bclk falling edge; i2s_lrclk = bit_cnt[5].
REQ-017 Standard I2S one-bit delay: bit_cnt 1..24 carry left bits 23..0; bit_cnt 33..56 carry right bits 23..0; all other slots drive 0.
REQ-018 The first falling edge after entering RUN SHALL be treated as bit_cnt 0 and load the shift register from the holding register.
REQ-019 At each wrap 63 -> 0 (frame boundary) the shift register SHALL load from the holding register if full, and the holding register SHALL become empty.
REQ-020 If the holding register is empty at a frame boundary, the frame SHALL transmit all zeros and underrun SHALL pulse for exactly one clk.
REQ-021 sample_ready = holding empty; it SHALL deassert the cycle after acceptance and reassert the cycle after the frame-boundary transfer.
REQ-022 A handshake in the same cycle as a boundary with an empty holding register SHALL be captured into holding (not transmitted this frame); underrun still pulses.
REQ-023 sample_left/right SHALL be sampled only on valid&ready; changes while ready=0 SHALL have no effect.
REQ-024 Data latency: accepted pair appears on i2s_data starting at bit_cnt 1 of the next frame boundary.

Reset
REQ-025 On reset=1 at a clk edge, the FSM SHALL enter IDLE and outputs SHALL be: sample_ready=1, i2s_bclk=0, i2s_lrclk=1, i2s_data=0, underrun=0; holding emptied, counters cleared.
REQ-026 Reset mid-frame SHALL discard the in-flight frame and held pair; no partial bits after the reset cycle.

Structure
REQ-027 Package i2s_pkg SHALL hold DATA_W=24, SLOT_W=32, FRAME_BITS=64 and the state enum typedef (IDLE, RUN), shared with i2s_receiver.
REQ-028 Sub-module i2s_clk_gen SHALL generate i2s_bclk plus one-clk bclk_rise/bclk_fall strobes from clk, enable and CLK_DIV.
REQ-029 The block SHALL use only clk; no logic clocked by i2s_bclk.

Verification
REQ-030 Reset, hold sample_valid=0 for 2000 clk -> bclk=0, lrclk=1, data=0, ready=1, no underrun.
REQ-031 CLK_DIV=8, send left=24'hA5A5A5, right=24'h5A5A5A -> bclk period 16 clk, lrclk period 1024 clk, captured on bclk rising edges: left MSB at bit_cnt 1, bits match, padding zero.
REQ-032 Continuous valid with ramp data 0,1,2,... -> every frame carries the next value, ready pulses once per 1024 clk, underrun never asserts.
REQ-033 Send one pair then stop -> following frame all zeros, underrun pulses exactly once per empty frame.
REQ-034 Assert reset for 1 clk at bit_cnt 10 of a frame with left=24'h800000 -> outputs reach reset values next cycle, FSM IDLE, held pair lost.
REQ-035 Loopback through i2s_receiver with left=24'h7FFFFF, right=24'h800001 -> receiver audio_left/audio_right equal the sent values.
